// File: rtl/doc_nut_if.sv
// Button bundle between raw contacts and the debounced event outputs.
// The release pulse is called rel because release is a reserved word in SystemVerilog.
interface doc_nut_if #(
  parameter int N = 2
);
  logic [N-1:0] btn_raw;
  logic [N-1:0] level;
  logic [N-1:0] press;
  logic [N-1:0] rel;
  logic [N-1:0] long_press;
  logic         tick;

  modport master (output btn_raw, input level, press, rel, long_press, tick);
  modport slave  (input btn_raw, output level, press, rel, long_press, tick);
endinterface

// File: rtl/doc_nut.sv
// doc_nut: N-bit button debouncer with press, release and long-press pulses.
// Hold counters and long_press are built only when DOC_NUT_LONG_EN is defined.
module doc_nut #(
  parameter int N        = 2,
  parameter int CLK_DIV  = 50000,
  parameter int DB_CNT   = 8,
  parameter int LONG_CNT = 1000
) (
  input logic      clk,
  input logic      rst_n,
  doc_nut_if.slave bus
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DB_W  = $clog2(DB_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DB_CNT);
  localparam logic [DB_W-1:0]  DB_ONE  = DB_W'(1);

  if (CLK_DIV < 1 || DB_CNT < 1 || LONG_CNT < 1) begin : g_bad_param
    $error("doc_nut: CLK_DIV, DB_CNT and LONG_CNT must be 1 or more");
  end

  typedef enum logic [1:0] {RELEASED, DB_PRESS, PRESSED, DB_RELEASE} state_t;

  logic [N-1:0]     sync_p0, sync_p1;
  logic [DIV_W-1:0] div_cnt;
  logic             tick_c;
  state_t           state_q [N];
  state_t           state_d [N];
  logic [DB_W-1:0]  cnt_q [N];
  logic [DB_W-1:0]  cnt_d [N];
  logic [N-1:0]     level_q, level_d, press_q, press_d, rel_q, rel_d;

  assign tick_c = (div_cnt == DIV_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      div_cnt <= tick_c ? '0 : div_cnt + DIV_ONE;
      sync_p0 <= bus.btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Per-bit debounce FSM, advanced only on sample ticks
  always_comb begin
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (tick_c) begin
        unique case (state_q[i])
          RELEASED: if (sync_p1[i]) begin
            if (DB_CNT == 1) state_d[i] = PRESSED;
            else begin
              state_d[i] = DB_PRESS;
              cnt_d[i]   = DB_ONE;
            end
          end
          DB_PRESS: if (!sync_p1[i]) begin
            state_d[i] = RELEASED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] + DB_ONE == DB_MAX) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else cnt_d[i] = cnt_q[i] + DB_ONE;
          PRESSED: if (!sync_p1[i]) begin
            if (DB_CNT == 1) state_d[i] = RELEASED;
            else begin
              state_d[i] = DB_RELEASE;
              cnt_d[i]   = DB_ONE;
            end
          end
          DB_RELEASE: if (sync_p1[i]) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] + DB_ONE == DB_MAX) begin
            state_d[i] = RELEASED;
            cnt_d[i]   = '0;
          end else cnt_d[i] = cnt_q[i] + DB_ONE;
        endcase
      end
      level_d[i] = (state_d[i] == PRESSED) || (state_d[i] == DB_RELEASE);
      press_d[i] = level_d[i] & ~level_q[i];
      rel_d[i]   = ~level_d[i] & level_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= RELEASED;
        cnt_q[i]   <= '0;
      end
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign bus.level = level_q;
  assign bus.press = press_q;
  assign bus.rel   = rel_q;
  assign bus.tick  = tick_c & rst_n;

`ifdef DOC_NUT_LONG_EN
  localparam int HLD_W = $clog2(LONG_CNT + 1);
  localparam logic [HLD_W-1:0] HLD_MAX = HLD_W'(LONG_CNT);
  localparam logic [HLD_W-1:0] HLD_ONE = HLD_W'(1);

  logic [HLD_W-1:0] hold_q [N];
  logic [HLD_W-1:0] hold_d [N];
  logic [N-1:0]     long_q, long_d;

  // A fresh press restarts the hold; bounces back from DB_RELEASE keep it
  always_comb begin
    for (int i = 0; i < N; i++) begin
      hold_d[i] = hold_q[i];
      long_d[i] = 1'b0;
      if (press_d[i]) hold_d[i] = '0;
      else if (tick_c && level_q[i] && hold_q[i] != HLD_MAX) begin
        hold_d[i] = hold_q[i] + HLD_ONE;
        long_d[i] = (hold_q[i] + HLD_ONE == HLD_MAX);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) hold_q[i] <= '0;
      long_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) hold_q[i] <= hold_d[i];
      long_q <= long_d;
    end
  end

  assign bus.long_press = long_q;
`else
  assign bus.long_press = '0;
`endif
endmodule

// File: tb/tb_doc_nut.sv
// Scoreboard bench for doc_nut: a tick-level behavioural model queues the expected
// outputs for every clock and a separate monitor compares them against the DUT.
module tb_doc_nut;
  localparam int N        = 2;
  localparam int CLK_DIV  = 4;
  localparam int DB_CNT   = 3;
  localparam int LONG_CNT = 5;

  typedef struct packed {
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] lng;
    logic         tick;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  doc_nut_if #(.N(N)) bus ();

  doc_nut #(
    .N(N), .CLK_DIV(CLK_DIV), .DB_CNT(DB_CNT), .LONG_CNT(LONG_CNT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model: sync delay line, cycle count since reset, per-bit level/run/hold
  logic [N-1:0] m_s0, m_s1, m_lvl, m_press, m_rel, m_long;
  int           m_cyc;
  int           m_diff [N];
  int           m_hold [N];

  task automatic model_reset();
    m_s0 = '0; m_s1 = '0; m_lvl = '0;
    m_press = '0; m_rel = '0; m_long = '0;
    m_cyc = 0;
    for (int i = 0; i < N; i++) begin
      m_diff[i] = 0;
      m_hold[i] = 0;
    end
  endtask

  task automatic model_clock();
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_press = '0; m_rel = '0; m_long = '0;
    if (m_cyc % CLK_DIV == CLK_DIV - 1) begin
      for (int i = 0; i < N; i++) begin
        if (m_lvl[i] && m_hold[i] < LONG_CNT) begin
          m_hold[i]++;
`ifdef DOC_NUT_LONG_EN
          if (m_hold[i] == LONG_CNT) m_long[i] = 1'b1;
`endif
        end
        if (m_s1[i] != m_lvl[i]) begin
          m_diff[i]++;
          if (m_diff[i] == DB_CNT) begin
            m_lvl[i]  = ~m_lvl[i];
            m_diff[i] = 0;
            if (m_lvl[i]) begin
              m_press[i] = 1'b1;
              m_hold[i]  = 0;
            end else m_rel[i] = 1'b1;
          end
        end else m_diff[i] = 0;
      end
    end
    m_s1 = m_s0;
    m_s0 = bus.btn_raw;
    m_cyc++;
  endtask

  task automatic step(input logic r, input logic [N-1:0] b);
    obs_t e;
    @(posedge clk);
    model_clock();
    #1;
    rst_n       = r;
    bus.btn_raw = b;
    if (!rst_n) model_reset();
    e.level = m_lvl;
    e.press = m_press;
    e.rel   = m_rel;
    e.lng   = m_long;
    e.tick  = rst_n && (m_cyc % CLK_DIV == CLK_DIV - 1);
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic [N-1:0] b, input int n);
    repeat (n) step(r, b);
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, want, $time);
    end
  endtask

  initial begin
    forever begin
      obs_t e;
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("level",      32'(bus.level),      32'(e.level));
        check("press",      32'(bus.press),      32'(e.press));
        check("release",    32'(bus.rel),        32'(e.rel));
        check("long_press", 32'(bus.long_press), 32'(e.lng));
        check("tick",       32'(bus.tick),       32'(e.tick));
      end
    end
  end

  initial begin
    bus.btn_raw = '0;
    model_reset();
    drive(1'b0, 2'b00, 3);
    drive(1'b1, 2'b00, 40);
    drive(1'b1, 2'b01, 30);
    drive(1'b1, 2'b00, 30);
    drive(1'b1, 2'b01, 8);
    drive(1'b1, 2'b00, 30);
    drive(1'b1, 2'b10, 60);
    drive(1'b1, 2'b00, 30);
    drive(1'b1, 2'b01, 6);
    drive(1'b0, 2'b01, 1);
    drive(1'b1, 2'b01, 30);
    drive(1'b1, 2'b00, 30);
    drive(1'b1, 2'b11, 40);
    drive(1'b1, 2'b00, 40);
    drive(1'b1, 2'b10, 30);
    drive(1'b1, 2'b00, 2);
    drive(1'b1, 2'b10, 40);
    drive(1'b1, 2'b00, 30);
    repeat (200) begin
      if ($urandom_range(0, 29) == 0) drive(1'b0, N'($urandom), 1);
      else drive(1'b1, N'($urandom), int'($urandom_range(1, 30)));
    end
    drive(1'b1, 2'b00, 20);
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/doc_nut.md
DOC_NUT -- requirements
Module: doc_nut

Interface
REQ-001 SHALL have parameter N, default 2: number of independent button/switch inputs.
REQ-002 SHALL have parameter CLK_DIV, default 50000: clk cycles per sample tick; legal range 1 or more.
REQ-003 SHALL have parameter DB_CNT, default 8: consecutive differing tick samples needed to accept a change; legal range 1 or more.
REQ-004 SHALL have parameter LONG_CNT, default 1000: ticks of stable press before a long-press event; legal range 1 or more.
REQ-005 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port btn_raw, input, N bits: asynchronous raw contacts, 1 = pressed.
REQ-008 SHALL have port level, output, N bits: debounced state, registered.
REQ-009 SHALL have port press, output, N bits: one-clk pulse on accepted press.
REQ-010 SHALL have port release, output, N bits: one-clk pulse on accepted release.
REQ-011 SHALL have port long_press, output, N bits: one-clk pulse per hold reaching LONG_CNT.
REQ-012 SHALL have port tick, output, 1 bit: sample-tick strobe, one clk wide.

Function
REQ-013 SHALL pass each btn_raw bit through a 2-flop synchronizer before any other use.
REQ-014 SHALL use a free-running divider counting 0..CLK_DIV-1 and wrapping to 0; tick=1 in the cycle the count equals CLK_DIV-1; CLK_DIV=1 gives tick every cycle.
REQ-015 SHALL give each bit its own FSM with states RELEASED, DB_PRESS, PRESSED, DB_RELEASE; bits never interact.
REQ-016 SHALL evaluate the FSM only on tick cycles; the synchronized sample is taken in the tick cycle.
REQ-017 RELEASED: a sample of 1 goes to DB_PRESS with the debounce count set to 1; if DB_CNT=1, it goes straight to PRESSED instead.
REQ-018 DB_PRESS: a sample of 1 increments the count; when the count reaches DB_CNT it goes to PRESSED; a sample of 0 returns to RELEASED and clears the count.
REQ-019 PRESSED and DB_RELEASE SHALL mirror REQ-017 and REQ-018 with sample 0, ending in RELEASED.
REQ-020 level SHALL be 1 exactly in PRESSED and DB_RELEASE; press/release SHALL pulse in the same clk edge at which level rises/falls, for exactly one cycle.
REQ-021 Worst-case latency from a btn_raw edge to a level change SHALL be 2 clk (synchronizer) + DB_CNT ticks; a glitch shorter than DB_CNT ticks SHALL cause no output change.
REQ-022 On entry to PRESSED the hold counter SHALL clear, then increment on each tick while in PRESSED or DB_RELEASE.
REQ-023 long_press SHALL pulse once, on the tick where hold reaches LONG_CNT; hold SHALL then saturate with no further pulses until the next release.
REQ-024 A bounce during DB_RELEASE that returns to PRESSED SHALL NOT reset the hold counter.
REQ-025 Release after a long press SHALL still pulse release; simultaneous events on different bits SHALL pulse in the same cycle.
REQ-026 Counter widths SHALL be $clog2(max value + 1) and SHALL never wrap.

Reset
REQ-027 While rst_n=0: level, press, release, long_press, tick and all counters = 0; synchronizers = 0; all FSMs in RELEASED.
REQ-028 Reset mid-debounce or mid-hold SHALL discard partial counts and SHALL produce no pulse.
REQ-029 A button held across reset deassertion SHALL produce press only after a full new debounce.

Configuration
REQ-030 With macro DOC_NUT_LONG_EN defined, hold counters and long_press SHALL behave per REQ-022 to REQ-024.
REQ-031 Without DOC_NUT_LONG_EN, long_press SHALL be constant 0, no hold counters SHALL be built, and all other behaviour SHALL be unchanged.

Verification (N=2, CLK_DIV=4, DB_CNT=3, LONG_CNT=5, DOC_NUT_LONG_EN defined)
REQ-032 Reset, then btn_raw=00 for 40 clk -> all outputs 0; tick pulses every 4th clk.
REQ-033 btn_raw[0] 0->1 held -> level[0]=1 and press[0]=1 for one clk on the 3rd tick after the sync delay; level[1] stays 0.
REQ-034 btn_raw[0]=1 for 2 ticks then 0 (glitch) -> level, press and release stay 0.
REQ-035 Hold btn_raw[1] for 15 ticks -> exactly one long_press[1] pulse, 5 ticks after level[1] rises; release -> one release[1] pulse and no further long_press.
REQ-036 rst_n low for 1 clk with btn_raw[0]=1 in DB_PRESS -> outputs 0; press[0] follows 3 ticks after reset release.
REQ-037 Rebuild without DOC_NUT_LONG_EN and repeat REQ-035 -> long_press stays 0; press/release timing identical.
